// File: rtl/alu_serial_ctrl_if.sv
// Request/response bundle between a datapath master and the bit-serial ALU sequencer.
interface alu_serial_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    modport master (
        output start, op, a, b,
        input  busy, done, err, result, carry_out, overflow, zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, err, result, carry_out, overflow, zero
    );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer driving one external 1-bit alu1 slice, LSB first,
// chaining the slice carry through a register between bits.
module alu_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    alu_serial_ctrl_if.slave    bus,
    output logic                alu_a,
    output logic                alu_b,
    output logic                alu_cin,
    output logic [2:0]          alu_control,
    input  logic                alu_out,
    input  logic                alu_cout
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam int CW = $clog2(WIDTH);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [2:0]       op_r;
    logic [CW-1:0]    cnt;
    logic             cy;
    logic [WIDTH-1:0] result_r;
    logic             carry_r;
    logic             ovf_r;
    logic             zero_r;
    logic             err_r;

    logic             running;
    logic             arith;
    logic             last_bit;
    logic [WIDTH-1:0] res_next;

    assign running  = (state == RUN);
    assign arith    = ~op_r[2];
    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign res_next = {alu_out, res_sh[WIDTH-1:1]};

    // Slice inputs are forced low outside RUN so the alu1 can be shared while idle.
    assign alu_a       = running & a_sh[0];
    assign alu_b       = running & b_sh[0];
    assign alu_cin     = running & cy;
    assign alu_control = running ? op_r : '0;

    assign bus.busy      = running;
    assign bus.done      = (state == DONE);
    assign bus.err       = err_r;
    assign bus.result    = result_r;
    assign bus.carry_out = carry_r;
    assign bus.overflow  = ovf_r;
    assign bus.zero      = zero_r;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            op_r     <= '0;
            cnt      <= '0;
            cy       <= 1'b0;
            result_r <= '0;
            carry_r  <= 1'b0;
            ovf_r    <= 1'b0;
            zero_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.op[2:1] != 2'b00) begin
                            a_sh  <= bus.a;
                            b_sh  <= bus.b;
                            op_r  <= bus.op;
                            cnt   <= '0;
                            // SUB seeds carry=1 so the slice forms a + ~b + 1.
                            cy    <= bus.op[0];
                            err_r <= 1'b0;
                            state <= RUN;
                        end else begin
                            err_r    <= 1'b1;
                            result_r <= '0;
                            carry_r  <= 1'b0;
                            ovf_r    <= 1'b0;
                            zero_r   <= 1'b0;
                            state    <= DONE;
                        end
                    end
                end
                RUN: begin
                    res_sh <= res_next;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cy     <= alu_cout;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        // Overflow: carry into the MSB differs from carry out of it.
                        result_r <= res_next;
                        carry_r  <= arith & alu_cout;
                        ovf_r    <= arith & (cy ^ alu_cout);
                        zero_r   <= (res_next == '0);
                        state    <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
